// File: rtl/game_pkg.sv
// Shared game-flow definitions: phase codes used by the sequencer, datapath and renderer.
package game_pkg;

    localparam int SCORE_W = 16;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_DYING     = 3'd4,
        ST_OVER      = 3'd5
    } game_state_e;

    function automatic logic [SCORE_W-1:0] score_max(input logic [SCORE_W-1:0] a,
                                                     input logic [SCORE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Frame prescaler: emits a one-cycle tick every DIV enabled cycles, restartable via clr.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // tick is raised while the count sits at its wrap value, so the consumer acts
    // on the edge where the count returns to zero, DIV cycles after a clear.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d  = (cnt_q == CNT_W'(DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
            tick_d = (cnt_q == CNT_W'(DIV - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences the physics datapath through countdown, play, pause and death.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 10_000_000,
    parameter int COUNT_START = 3,
    parameter int COUNT_TICKS = 10,
    parameter int DEATH_TICKS = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               collide,
    input  logic [SCORE_W-1:0] score_in,
    output logic [STATE_W-1:0] state,
    output logic               dp_tick,
    output logic               dp_clear,
    output logic [1:0]         countdown,
    output logic [SCORE_W-1:0] best_score
);

    localparam int SUB_W = $clog2(COUNT_TICKS) + 1;
    localparam int DTH_W = $clog2(DEATH_TICKS) + 1;

    logic [1:0]         btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
    game_state_e        state_q, state_d;
    logic [1:0]         countdown_q, countdown_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [DTH_W-1:0]   death_q, death_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               dp_clear_q, dp_clear_d;
    logic               tb, start_edge, pause_edge;

    // bit 0 = start, bit 1 = pause; two flops for metastability, third for edge detect
    always_comb begin
        btn_s1_d   = {pause_btn, start_btn};
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
    end

    assign start_edge = btn_s2_q[0] & ~btn_prev_q[0];
    assign pause_edge = btn_s2_q[1] & ~btn_prev_q[1];

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .en   (state_q != ST_PAUSED),
        .tick (tb)
    );

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        sub_d       = sub_q;
        death_d     = death_q;
        best_d      = best_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = 2'(COUNT_START);
                    sub_d       = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (tb) begin
                    if (sub_q == SUB_W'(COUNT_TICKS - 1)) begin
                        sub_d = '0;
                        if (countdown_q == 2'd1) begin
                            state_d     = ST_RUNNING;
                            countdown_d = 2'd0;
                        end else begin
                            countdown_d = countdown_q - 2'd1;
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
            end
            ST_RUNNING: begin
                if (collide) begin
                    state_d = ST_DYING;
                    death_d = '0;
                    best_d  = score_max(best_q, score_in);
                end else if (pause_edge) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_edge) state_d = ST_RUNNING;
            end
            ST_DYING: begin
                if (tb) begin
                    if (death_q == DTH_W'(DEATH_TICKS - 1)) state_d = ST_OVER;
                    else                                    death_d = death_q + DTH_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                countdown_d = 2'd0;
            end
        endcase
        dp_clear_d = (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            btn_prev_q  <= '0;
            state_q     <= ST_IDLE;
            countdown_q <= '0;
            sub_q       <= '0;
            death_q     <= '0;
            best_q      <= '0;
            dp_clear_q  <= 1'b0;
        end else begin
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            btn_prev_q  <= btn_prev_d;
            state_q     <= state_d;
            countdown_q <= countdown_d;
            sub_q       <= sub_d;
            death_q     <= death_d;
            best_q      <= best_d;
            dp_clear_q  <= dp_clear_d;
        end
    end

    assign state      = state_q;
    assign dp_tick    = tb && (state_q == ST_RUNNING);
    assign dp_clear   = dp_clear_q;
    assign countdown  = countdown_q;
    assign best_score = best_q;

endmodule
